register_writeback: RTL

//  Writer side of the 32x32 register file: accepts one retiring instruction's writeback request,

---
 rtl/register_writeback.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/register_writeback.sv
// rtl/register_writeback.sv - register-file writeback sequencer with load alignment and memory timeout
//
// Accepts one retiring instruction's writeback request at a time. It selects the result
// source (ALU, load, PC+4, immediate). For loads it checks alignment, waits for data memory,
// and then extracts and extends the addressed byte, halfword or word. It finishes with one
// registered write toward the register file.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   wb_valid           request strobe, only looked at while idle
//   rd                 destination register
//   wb_sel             0=ALU 1=MEM 2=PC+4 3=IMM
//   funct3             load width (LB/LH/LW/LBU/LHU)
//   alu_result         ALU result; [1:0] is the byte offset for loads
//   pc_plus4, imm      alternative result sources
//   mem_read_data      word-aligned load data
//   mem_valid          load data valid (only honoured while waiting for memory)
//   write_enable_flag  register-file write enable pulse
//   a3                 register-file write address
//   write_data_input   register-file write data
//   busy               high while waiting for memory or writing
//   done               pulse when a request retires
//   err                pulse on misaligned load, bad funct3 or memory timeout

module register_writeback #(
   parameter int CLK_FREQ    = 12000000,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic [4:0]  rd,
   input  logic [1:0]  wb_sel,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_result,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] imm,
   input  logic [31:0] mem_read_data,
   input  logic        mem_valid,
   output logic        write_enable_flag,
   output logic [4:0]  a3,
   output logic [31:0] write_data_input,
   output logic        busy,
   output logic        done,
   output logic        err
);

   generate
      if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CLK_FREQ < 1) begin : g_bad_param
         $error("register_writeback: parameter out of range");
      end
   endgenerate

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WAIT_MEM = 2'd1;
   localparam logic [1:0] S_WRITE    = 2'd2;

   localparam logic [1:0] SEL_ALU = 2'd0;
   localparam logic [1:0] SEL_MEM = 2'd1;
   localparam logic [1:0] SEL_PC4 = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // The last counter value that may still wait. The counter runs from 0 up to this value,
   // so a load waits MEM_TIMEOUT cycles in total.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   logic [1:0]  state;
   logic [4:0]  rd_q;
   logic [2:0]  funct3_q;
   logic [1:0]  offset_q;
   logic [7:0]  counter;

   logic [31:0] sel_value;
   logic        load_legal;
   logic [31:0] byte_shift;
   logic [31:0] half_shift;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [31:0] load_value;

   // Non-load result source.
   always_comb begin
      sel_value = imm;
      case (wb_sel)
         SEL_ALU: sel_value = alu_result;
         SEL_PC4: sel_value = pc_plus4;
         default: sel_value = imm;
      endcase
   end

   // Alignment / width legality of an incoming load request.
   always_comb begin
      load_legal = 1'b0;
      case (funct3)
         F3_LB, F3_LBU: load_legal = 1'b1;
         F3_LH, F3_LHU: load_legal = ~alu_result[0];
         F3_LW:         load_legal = (alu_result[1:0] == 2'b00);
         default:       load_legal = 1'b0;
      endcase
   end

   // Load data extraction. The byte lane is picked by the full offset. The halfword lane is
   // picked by offset[1] only, because offset[0] is already known to be 0 for halfwords.
   always_comb begin
      byte_shift = mem_read_data >> {offset_q, 3'b000};
      half_shift = mem_read_data >> {offset_q[1], 4'b0000};
      byte_val   = byte_shift[7:0];
      half_val   = half_shift[15:0];
      load_value = mem_read_data;
      case (funct3_q)
         F3_LB:   load_value = {{24{byte_val[7]}}, byte_val};
         F3_LH:   load_value = {{16{half_val[15]}}, half_val};
         F3_LBU:  load_value = {24'd0, byte_val};
         F3_LHU:  load_value = {16'd0, half_val};
         default: load_value = mem_read_data;
      endcase
   end

   // Outputs are registered on entry to WRITE, so they are visible exactly during the
   // single WRITE cycle. Pulses default low every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= S_IDLE;
         rd_q              <= 5'd0;
         funct3_q          <= 3'd0;
         offset_q          <= 2'd0;
         counter           <= 8'd0;
         write_enable_flag <= 1'b0;
         a3                <= 5'd0;
         write_data_input  <= 32'd0;
         done              <= 1'b0;
         err               <= 1'b0;
      end else begin
         write_enable_flag <= 1'b0;
         done              <= 1'b0;
         err               <= 1'b0;
         case (state)
            S_IDLE: begin
               if (wb_valid) begin
                  if (wb_sel != SEL_MEM) begin
                     write_enable_flag <= (rd != 5'd0);
                     a3                <= rd;
                     write_data_input  <= sel_value;
                     done              <= 1'b1;
                     state             <= S_WRITE;
                  end else if (!load_legal) begin
                     err  <= 1'b1;
                     done <= 1'b1;
                  end else begin
                     rd_q     <= rd;
                     funct3_q <= funct3;
                     offset_q <= alu_result[1:0];
                     counter  <= 8'd0;
                     state    <= S_WAIT_MEM;
                  end
               end
            end
            S_WAIT_MEM: begin
               // mem_valid is checked first, so data arriving on the last allowed cycle still wins.
               if (mem_valid) begin
                  write_enable_flag <= (rd_q != 5'd0);
                  a3                <= rd_q;
                  write_data_input  <= load_value;
                  done              <= 1'b1;
                  state             <= S_WRITE;
               end else if (counter == TIMEOUT_LAST) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  counter <= counter + 8'd1;
               end
            end
            S_WRITE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_WAIT_MEM) || (state == S_WRITE);

endmodule
